// File: rtl/counter_updown_param.sv
// Parametrised up/down/bounce/hold counter with programmable limit, load and enable.
// Bounds either wrap (with a registered wrap pulse) or saturate, selected by SATURATE.
module counter_updown_param #(
  parameter int unsigned WIDTH    = 10,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam int unsigned W = WIDTH;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [W-1:0] cnt_nxt;
  logic         dir_nxt;
  logic         wrap_nxt;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] cnt_dec;
  logic [W-1:0] lim_m1;
  logic         lim_zero;
  logic         cnt_zero;
  mode_e        mode_q;

  assign mode_q   = mode_e'(mode);
  assign cnt_inc  = cnt + W'(1);
  assign cnt_dec  = cnt - W'(1);
  assign lim_m1   = limit - W'(1);
  assign lim_zero = (limit == '0);
  assign cnt_zero = (cnt == '0);

  // Next-state: load beats enable; wrap is a one-edge pulse unless re-armed.
  always_comb begin
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    wrap_nxt = 1'b0;
    if (load) begin
      cnt_nxt = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      case (mode_q)
        MODE_UP: begin
          dir_nxt = 1'b1;
          if (cnt < limit) begin
            cnt_nxt = cnt_inc;
          end else if (SATURATE) begin
            cnt_nxt = limit;
          end else begin
            cnt_nxt  = '0;
            wrap_nxt = 1'b1;
          end
        end
        MODE_DOWN: begin
          dir_nxt = 1'b0;
          if (cnt > limit) begin
            cnt_nxt = limit;
          end else if (!cnt_zero) begin
            cnt_nxt = cnt_dec;
          end else if (!SATURATE) begin
            cnt_nxt  = limit;
            wrap_nxt = 1'b1;
          end
        end
        MODE_BOUNCE: begin
          // Reversal takes the first step in the new direction on the same edge;
          // a zero limit pins cnt at 0 and just flips dir.
          if (dir) begin
            if (cnt < limit) begin
              cnt_nxt = cnt_inc;
            end else begin
              dir_nxt  = 1'b0;
              wrap_nxt = 1'b1;
              cnt_nxt  = lim_zero ? '0 : lim_m1;
            end
          end else begin
            if (cnt > limit) begin
              cnt_nxt = limit;
            end else if (!cnt_zero) begin
              cnt_nxt = cnt_dec;
            end else begin
              dir_nxt  = 1'b1;
              wrap_nxt = 1'b1;
              cnt_nxt  = lim_zero ? '0 : W'(1);
            end
          end
        end
        default: begin
          cnt_nxt = cnt;
          dir_nxt = dir;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      dir  <= 1'b1;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      dir  <= dir_nxt;
      wrap <= wrap_nxt;
    end
  end

  // Bound flags follow cnt and limit without a register stage.
  assign at_max = (cnt >= limit);
  assign at_min = cnt_zero;

endmodule

// File: tb/tb_counter_updown_param.sv
// Directed bench for counter_updown_param: a wrapping and a saturating instance
// share stimulus; expected values are hand-computed per step.
module tb_counter_updown_param;

  localparam int unsigned W = 10;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] limit;

  logic [W-1:0] cnt, cnt_s;
  logic         dir, dir_s;
  logic         wrap, wrap_s;
  logic         at_max, at_max_s;
  logic         at_min, at_min_s;

  int checks = 0;
  int errors = 0;

  int t1_cnt  [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
  int t1_wrap [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  int t2_cnt  [4] = '{1, 0, 1023, 1022};
  int t2_wrap [4] = '{0, 0, 1, 0};
  int t3_cnt  [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
  int t3_dir  [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
  int t3_wrap [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
  int l0_dir  [3] = '{0, 1, 0};

  counter_updown_param #(.WIDTH(W), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .limit(limit), .cnt(cnt), .dir(dir),
    .wrap(wrap), .at_max(at_max), .at_min(at_min)
  );

  counter_updown_param #(.WIDTH(W), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .limit(limit), .cnt(cnt_s), .dir(dir_s),
    .wrap(wrap_s), .at_max(at_max_s), .at_min(at_min_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0;
    load_val = '0; limit = 10'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt",    32'(cnt),    0);
    check("rst_dir",    32'(dir),    1);
    check("rst_wrap",   32'(wrap),   0);
    check("rst_at_min", 32'(at_min), 1);
    @(negedge clk);
    rst = 1'b1;

    // T1: up with wrap at limit 5
    en = 1'b1; mode = 2'b00; limit = 10'd5;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t1_cnt%0d", i),  32'(cnt),  32'(t1_cnt[i]));
      check($sformatf("t1_wrap%0d", i), 32'(wrap), 32'(t1_wrap[i]));
      if (i == 4) check("t1_at_max", 32'(at_max), 1);
      if (i == 5) check("t1_at_min", 32'(at_min), 1);
    end

    // T2: load 2, then count down through 0 to the natural 1023 wrap
    load = 1'b1; load_val = 10'd2; limit = 10'd1023; mode = 2'b01;
    step();
    check("t2_load_cnt", 32'(cnt),  2);
    check("t2_load_dir", 32'(dir),  1);
    check("t2_load_wrap", 32'(wrap), 0);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t2_cnt%0d", i),  32'(cnt),  32'(t2_cnt[i]));
      check($sformatf("t2_wrap%0d", i), 32'(wrap), 32'(t2_wrap[i]));
      check($sformatf("t2_dir%0d", i),  32'(dir),  0);
    end

    // T3: bounce between 0 and 3 starting at 0 going up
    pulse_reset();
    mode = 2'b10; limit = 10'd3; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t3_cnt%0d", i),  32'(cnt),  32'(t3_cnt[i]));
      check($sformatf("t3_dir%0d", i),  32'(dir),  32'(t3_dir[i]));
      check($sformatf("t3_wrap%0d", i), 32'(wrap), 32'(t3_wrap[i]));
    end

    // Bounce with limit 0: cnt pinned at 0, dir toggles, wrap every edge
    limit = 10'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("l0_cnt%0d", i),  32'(cnt),  0);
      check($sformatf("l0_dir%0d", i),  32'(dir),  32'(l0_dir[i]));
      check($sformatf("l0_wrap%0d", i), 32'(wrap), 1);
    end

    // T4: load clipped to limit, then limit lowered below cnt
    limit = 10'd500; load = 1'b1; load_val = 10'd900;
    step();
    check("t4_clip_cnt", 32'(cnt), 500);
    check("t4_clip_dir", 32'(dir), 0);
    load = 1'b0; limit = 10'd100; mode = 2'b01;
    step();
    check("t4_down_cnt",  32'(cnt),  100);
    check("t4_down_wrap", 32'(wrap), 0);
    mode = 2'b00;
    step();
    check("t4_up_cnt",  32'(cnt),  0);
    check("t4_up_wrap", 32'(wrap), 1);
    check("t4_up_dir",  32'(dir),  1);

    // Hold mode and idle both freeze cnt and clear wrap
    mode = 2'b11;
    step();
    check("hold_cnt",  32'(cnt),  0);
    check("hold_wrap", 32'(wrap), 0);
    mode = 2'b00;
    step();
    check("up_after_hold", 32'(cnt), 1);
    en = 1'b0;
    step();
    check("idle_cnt", 32'(cnt), 1);

    // T5: saturating instance holds at limit 7 and at 0
    pulse_reset();
    en = 1'b1; mode = 2'b00; limit = 10'd7;
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("t5_cnt%0d", i),  32'(cnt_s),  32'((i > 7) ? 7 : i));
      check($sformatf("t5_wrap%0d", i), 32'(wrap_s), 0);
    end
    check("t5_at_max", 32'(at_max_s), 1);
    load = 1'b1; load_val = 10'd0;
    step();
    load = 1'b0; mode = 2'b01;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("t5_down_cnt%0d", i),  32'(cnt_s),  0);
      check($sformatf("t5_down_wrap%0d", i), 32'(wrap_s), 0);
    end

    // T6: async reset between edges at cnt=37
    mode = 2'b00; limit = 10'd1023; load = 1'b1; load_val = 10'd36;
    step();
    load = 1'b0;
    step();
    check("t6_pre_cnt", 32'(cnt), 37);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_cnt",  32'(cnt),  0);
    check("t6_rst_dir",  32'(dir),  1);
    check("t6_rst_wrap", 32'(wrap), 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("t6_resume1", 32'(cnt), 1);
    step();
    check("t6_resume2", 32'(cnt), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
